// File: rtl/ultrasonic_sensor_uart_frame_tx_if.sv
// Bundle between the ASCII converter and the UART frame transmitter.
//   Digits_i            packed ASCII digits, MS digit in the top byte
//   Digits_Available_i  one-cycle pulse marking Digits_i valid
//   Uart_Tx_o           serial line, idle high
//   Busy_o              frame in flight
//   Frame_Done_o        one-cycle pulse after the last stop bit
//   Dropped_o           one-cycle pulse when a sample arrived while busy
// master: the converter side; slave: the transmitter side.
interface ultrasonic_sensor_uart_frame_tx_if #(
    parameter int unsigned NUM_DIGITS = 3
);
    logic [8*NUM_DIGITS-1:0] Digits_i;
    logic                    Digits_Available_i;
    logic                    Uart_Tx_o;
    logic                    Busy_o;
    logic                    Frame_Done_o;
    logic                    Dropped_o;

    modport master (
        output Digits_i,
        output Digits_Available_i,
        input  Uart_Tx_o,
        input  Busy_o,
        input  Frame_Done_o,
        input  Dropped_o
    );

    modport slave (
        input  Digits_i,
        input  Digits_Available_i,
        output Uart_Tx_o,
        output Busy_o,
        output Frame_Done_o,
        output Dropped_o
    );
endinterface

// File: rtl/ultrasonic_sensor_uart_frame_tx.sv
// UART 8N1 transmitter for HC-SR04 distance samples. Captures the packed ASCII
// digits on their availability pulse and sends "<digits> cm\r\n", with optional
// leading-zero blanking. Samples arriving while a frame is in flight are dropped
// and flagged.
// Ports:
//   Clk_i    system clock, rising edge
//   Reset_i  synchronous, active-high reset
//   bus      slave side of ultrasonic_sensor_uart_frame_tx_if (digits in,
//            serial line and status pulses out; all outputs registered)
module ultrasonic_sensor_uart_frame_tx #(
    parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
    parameter int unsigned BAUD_RATE      = 9600,
    parameter int unsigned NUM_DIGITS     = 3,
    parameter int unsigned SUPPRESS_ZEROS = 1
) (
    input  logic Clk_i,
    input  logic Reset_i,
    ultrasonic_sensor_uart_frame_tx_if.slave bus
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned FRAME_LEN    = NUM_DIGITS + 5;
    localparam int unsigned CntW         = $clog2(CLKS_PER_BIT);
    localparam int unsigned ByteW        = $clog2(FRAME_LEN);
    localparam int unsigned DigW         = 8 * NUM_DIGITS;

    localparam logic [CntW-1:0]  BaudLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [ByteW-1:0] ByteLast = ByteW'(FRAME_LEN - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [ByteW-1:0] byte_q, byte_d;
    logic [DigW-1:0]  digits_q, digits_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             drop_q, drop_d;
    logic             baud_end;
    logic [7:0]       cur_byte;

    // Blank leading '0' digits from the MS end; the LS digit is always kept.
    function automatic logic [DigW-1:0] suppress(input logic [DigW-1:0] d);
        logic lead;
        suppress = d;
        lead     = 1'b1;
        if (SUPPRESS_ZEROS != 0) begin
            for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
                if (lead && d[8*k +: 8] == 8'h30) begin
                    suppress[8*k +: 8] = 8'h20;
                end else begin
                    lead = 1'b0;
                end
            end
        end
    endfunction

    // Byte idx of the frame: digits MS first, then " cm\r\n".
    function automatic logic [7:0] frame_byte(input logic [ByteW-1:0] idx,
                                              input logic [DigW-1:0]  digs);
        int unsigned i;
        i = 32'(idx);
        if (i < NUM_DIGITS) begin
            frame_byte = digs[8*(NUM_DIGITS-1-i) +: 8];
        end else begin
            case (i - NUM_DIGITS)
                0:       frame_byte = 8'h20;
                1:       frame_byte = 8'h63;
                2:       frame_byte = 8'h6D;
                3:       frame_byte = 8'h0D;
                default: frame_byte = 8'h0A;
            endcase
        end
    endfunction

    // State and output registers.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            digits_q <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            digits_q <= digits_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            drop_q   <= drop_d;
        end
    end

    assign baud_end = (baud_q == BaudLast);

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        digits_d = digits_q;
        unique case (state_q)
            StIdle: begin
                if (bus.Digits_Available_i) begin
                    digits_d = suppress(bus.Digits_i);
                    byte_d   = '0;
                    baud_d   = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (byte_q != ByteLast) begin
                        byte_d  = byte_q + 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are derived from the next state so that, once registered, they
    // line up with the state they describe.
    always_comb begin
        tx_d     = 1'b1;
        cur_byte = frame_byte(byte_d, digits_d);
        unique case (state_d)
            StIdle:  tx_d = 1'b1;
            StStart: tx_d = 1'b0;
            StData:  tx_d = cur_byte[bit_d];
            StStop:  tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_q == StStop) && baud_end && (byte_q == ByteLast);
        drop_d = bus.Digits_Available_i && (state_q != StIdle);
    end

    assign bus.Uart_Tx_o    = tx_q;
    assign bus.Busy_o       = busy_q;
    assign bus.Frame_Done_o = done_q;
    assign bus.Dropped_o    = drop_q;

endmodule
